input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Parametrised N-channel front end for board switches/buttons: per channel synchroniser,
//  counter-based debounce and per-channel edge-mode pulse generation, plus a priority
//  encoder giving the lowest-index pulsing channel. Feeds single-cycle events to the PDU.
// PARAMETERS
//  NCH          21         number of input channels (5 buttons + 16 hex switches)
//  SYNC_STAGES  2          synchroniser flops per channel (>=2)
//  DB_CYCLES    1_000_000  consecutive differing samples needed to accept a change (>=1)
//  REP_DELAY    50_000_000 cycles from press to first repeat (AUTO_REPEAT_EN only)
//  REP_PERIOD   10_000_000 cycles between later repeats (AUTO_REPEAT_EN only)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          asynchronous reset, active-high
//  raw        in   NCH        asynchronous raw pad inputs
//  mode       in   2*NCH      per-channel edge mode, channel i in mode[2i+1:2i]
//  level      out  NCH        debounced stable level
//  pulse      out  NCH        one-cycle event per channel
//  key_valid  out  1          |pulse
//  key_code   out  clog2(NCH) index of lowest set bit of pulse; 0 when key_valid=0
// BEHAVIOUR
//  - Reset: sync chain, level, pulse, debounce counters, repeat state all 0; key_valid=0, key_code=0.
//  - Sync: raw[i] through SYNC_STAGES flops -> s[i].
//  - Debounce: if s[i]==level[i] counter clears. Else counter increments; when it reaches
//    DB_CYCLES-1 while still differing, level[i]<=s[i] and counter clears. Any agreeing
//    sample restarts the count. Raw-to-level latency = SYNC_STAGES + DB_CYCLES cycles.
//  - Pulse is registered and asserted in the same cycle level[i] takes its new value, one cycle wide:
//    mode 00 rise, 01 fall, 10 both edges, 11 none (level still tracked).
//  - Mode change takes effect on the next accepted change; never itself creates a pulse.
//  - Input held high through reset: level rises after full latency post-reset -> one rise pulse.
//  - Simultaneous pulses on several channels: all set in pulse; key_code = lowest index.
//  - key_valid/key_code combinational from registered pulse (no extra latency).
//  - Counter width clog2(DB_CYCLES+1); must never wrap.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: one shared repeat engine. A rise-qualified press pulse on channel c
//  (mode 00 or 10) loads target=c, timer=REP_DELAY. While level[c]=1 timer counts down; at 0
//  emits pulse[c] for one cycle and reloads REP_PERIOD. A newer press on any channel
//  retargets (same cycle, lowest index wins); level[c] falling stops engine, no pulse.
//  Repeat pulses OR into pulse and drive key_valid/key_code identically.
//  AUTO_REPEAT_EN undefined: engine and REP_* unused; exactly one pulse per accepted edge.
// STRUCTURE
//  Package input_cond_pkg: edge_mode_e {EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10,
//  EDGE_NONE=2'b11}; helper function lowest_set_index.
//  Sub-module input_cond_chan (sync + debounce + edge for one channel), generated NCH times;
//  priority encoder and repeat engine in the top of this block.
// TESTING (NCH=4, SYNC_STAGES=2, DB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8)
//  - raw[0] 0->1 held, mode0=00 -> level[0]=1 exactly 6 cycles later, pulse[0] 1 cycle, key_code=0.
//  - raw[1] bounce 1,0,1,1,0 then steady 1, mode1=01 -> no pulse during bounce; level[1]
//    rises 6 cycles after steady; on release, pulse[1] at fall only.
//  - raw[2],raw[3] rise same cycle, mode=10 -> pulse=4'b1100, key_code=2; releases pulse again.
//  - mode3=11, toggle raw[3] -> level follows, pulse[3] never set; rst mid-count clears all.
//  - AUTO_REPEAT_EN: hold raw[0] 60 cycles -> pulses at press, +20, +28, +36, +44 (and
//    +52 if still held); release stops repeats.
//  - raw[1]=1 during rst -> after deassert pulse[1] once at cycle 6 (mode 00).

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the switch/button input conditioner.
// Build option: AUTO_REPEAT_EN enables the shared key auto-repeat engine.
package input_cond_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;

  localparam int unsigned IDX_MAXW = 64;

  function automatic logic [5:0] lowest_set_index(
    input logic [IDX_MAXW-1:0] v
  );
    logic [5:0] idx;
    idx = '0;
    for (int i = IDX_MAXW - 1; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_cond_chan.sv
// One input channel: synchroniser, counter debounce, edge-mode pulse.
// Build option: none (AUTO_REPEAT_EN only affects the top).
module input_cond_chan
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_i,
  input  edge_mode_e mode_i,
  output logic       level_o,
  output logic       pulse_o
);

  localparam int CNTW = $clog2(DB_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   s;
  logic                   hit;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    hit = 1'b0;
    unique case (mode_i)
      EDGE_RISE: hit = s;
      EDGE_FALL: hit = ~s;
      EDGE_BOTH: hit = 1'b1;
      EDGE_NONE: hit = 1'b0;
    endcase
  end

  // Counter only advances on a disagreeing sample and clears on
  // acceptance, so it stops at CNT_LAST and can never wrap.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = s;
      pulse_d = hit;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// N-channel switch/button front end with lowest-index key encoder.
// Build option: AUTO_REPEAT_EN adds one shared auto-repeat engine.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NCH         = 21,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int REP_DELAY   = 50_000_000,
  parameter int REP_PERIOD  = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   raw,
  input  logic [2*NCH-1:0] mode,
  output logic [NCH-1:0]   level,
  output logic [NCH-1:0]   pulse,
  output logic             key_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] key_code
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int REP_MAX =
    (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int TW = $clog2(REP_MAX + 1);

`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic [NCH-1:0] cpulse;
  logic [NCH-1:0] press;
  logic [NCH-1:0] rpt_q, rpt_d;
  logic [CW-1:0]  tgt_q, tgt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           act_q, act_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    input_cond_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw[i]),
      .mode_i  (edge_mode_e'(mode[2*i +: 2])),
      .level_o (level[i]),
      .pulse_o (cpulse[i])
    );
  end

  // A channel pulse with level now high is a rise-qualified press.
  assign press = cpulse & level & {NCH{REP_EN}};

  // Timer is loaded one cycle after the press and the repeat pulse
  // is registered, hence the -2 / -1 load values.
  always_comb begin
    act_d = act_q;
    tgt_d = tgt_q;
    tmr_d = tmr_q;
    rpt_d = '0;
    if (|press) begin
      act_d = 1'b1;
      tgt_d = CW'(lowest_set_index(IDX_MAXW'(press)));
      tmr_d = TW'(REP_DELAY - 2);
    end else if (act_q) begin
      if (!level[tgt_q]) begin
        act_d = 1'b0;
      end else if (tmr_q == '0) begin
        rpt_d[tgt_q] = 1'b1;
        tmr_d        = TW'(REP_PERIOD - 1);
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      tgt_q <= '0;
      tmr_q <= '0;
      rpt_q <= '0;
    end else begin
      act_q <= act_d;
      tgt_q <= tgt_d;
      tmr_q <= tmr_d;
      rpt_q <= rpt_d;
    end
  end

  assign pulse     = cpulse | (rpt_q & level);
  assign key_valid = |pulse;
  assign key_code  = CW'(lowest_set_index(IDX_MAXW'(pulse)));

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (NCH=4, DB_CYCLES=4).
// Build option: AUTO_REPEAT_EN enables repeat expectations.
module tb_input_conditioner;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] raw;
  logic [7:0]     mode;
  logic [NCH-1:0] level;
  logic [NCH-1:0] pulse;
  logic           key_valid;
  logic [1:0]     key_code;

  input_conditioner #(
    .NCH         (NCH),
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .REP_DELAY   (RD),
    .REP_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw),
    .mode      (mode),
    .level     (level),
    .pulse     (pulse),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] pul;
    logic       kv;
    logic [1:0] kc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic int lowest(input bit [3:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Reference: raw seen through a 2-sample delay line; level flips once
  // DB consecutive delayed samples disagree with it.
  bit [3:0] m_d1, m_d2, m_lvl;
  int       m_run [NCH];
  bit       m_act;
  int       m_tgt;
  int       m_t0;

  always @(posedge clk) begin : model
    exp_t     e;
    bit [3:0] cp;
    bit [3:0] rp;
    bit [3:0] pr;
    bit       s;
    bit [1:0] m;
    cyc++;
    cp = '0;
    rp = '0;
    pr = '0;
    if (rst) begin
      m_d1  = '0;
      m_d2  = '0;
      m_lvl = '0;
      m_act = 1'b0;
      for (int i = 0; i < NCH; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        s = m_d2[i];
        if (s == m_lvl[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_run[i] = 0;
            m_lvl[i] = s;
            m = mode[2*i +: 2];
            cp[i] = (m == 2'd0 && s) || (m == 2'd1 && !s) ||
                    (m == 2'd2);
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = raw;
`ifdef AUTO_REPEAT_EN
      if (m_act && !m_lvl[m_tgt]) m_act = 1'b0;
      if (m_act && (cyc - m_t0) >= RD &&
          ((cyc - m_t0 - RD) % RP) == 0)
        rp[m_tgt] = 1'b1;
      pr = cp & m_lvl;
      if (pr != 0) begin
        m_act = 1'b1;
        m_t0  = cyc;
        m_tgt = lowest(pr);
      end
`endif
    end
    e.lvl = m_lvl;
    e.pul = cp | rp;
    e.kv  = |(cp | rp);
    e.kc  = 2'(lowest(cp | rp));
    sb_q.push_back(e);
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (rst) e = '0;
      chk("level", int'(level), int'(e.lvl));
      chk("pulse", int'(pulse), int'(e.pul));
      chk("key_valid", int'(key_valid), int'(e.kv));
      chk("key_code", int'(key_code), int'(e.kc));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    raw  = '0;
    mode = 8'b11_10_01_00;
    tick(3);
    rst = 1'b0;
    tick(2);
    // ch0 rise, long hold for repeats, then release
    raw[0] = 1'b1;
    tick(60);
    raw[0] = 1'b0;
    tick(20);
    // ch1 bounce then steady, fall-mode
    raw[1] = 1'b1; tick(1);
    raw[1] = 1'b0; tick(1);
    raw[1] = 1'b1; tick(2);
    raw[1] = 1'b0; tick(1);
    raw[1] = 1'b1;
    tick(15);
    raw[1] = 1'b0;
    tick(15);
    // ch2+ch3 same-cycle, both-edge mode
    mode[7:6] = 2'b10;
    raw[3:2] = 2'b11;
    tick(15);
    raw[3:2] = 2'b00;
    tick(15);
    // ch3 no-pulse mode, level still tracked
    mode[7:6] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      raw[3] = ~raw[3];
      tick(10);
    end
    // reset mid-count, ch1 held high through reset
    mode[3:2] = 2'b00;
    raw[0] = 1'b1;
    tick(3);
    raw[1] = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(40);
    raw = '0;
    tick(15);
    // random phase: fast toggles
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(5) == 0) raw[i] = ~raw[i];
      if ($urandom_range(39) == 0) mode = 8'($urandom);
      tick(1);
    end
    // random phase: slow toggles, long holds
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(40) == 0) raw[i] = ~raw[i];
      if ($urandom_range(99) == 0) mode = 8'($urandom);
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      tick(1);
    end
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
